conv3x3_stream: RTL

Parametrised 3x3 separable-kernel streaming filter for the image pipeline: accepts a raster-ordered frame at PIXELS_PER_BEAT pixels per beat and emits a same-size filtered frame. It is the next-generation Gaussian stage and adds:

- independent width and height;
- a valid/ready input handshake;
- selectable kernel mode and border policy;
- frame and line markers on the output;
- automatic flush of the last output row.

It sits between the input unpacker and the pyramid/fusion stages.

---
 rtl/conv3x3_stream.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 separable filter (gaussian, bypass, horizontal, vertical) over raster frames
// Ports: clk, aresetn (sync, active-low); stall freezes all state; in_valid/in_ready/in_frame input beats, pixel 0 in the MSB slice;
// mode/border sampled with beat (0,0); out_valid/out_frame output beats, out_sof on beat (0,0), out_eol on the last beat of a row.
module conv3x3_stream #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int INPUT_WIDTH = 8,
  parameter int IMAGE_WIDTH = 512,
  parameter int IMAGE_HEIGHT = 512,
  parameter int DATA_WIDTH = INPUT_WIDTH * PIXELS_PER_BEAT
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  stall,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_frame,
  input  logic [1:0]            mode,
  input  logic                  border,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_frame,
  output logic                  out_sof,
  output logic                  out_eol
);
  localparam int P = PIXELS_PER_BEAT;
  localparam int W = INPUT_WIDTH;
  localparam int COLS = IMAGE_WIDTH / PIXELS_PER_BEAT;
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMAGE_HEIGHT - 1);
  typedef logic [W-1:0] pix_t;
  typedef logic [W+3:0] acc_t;
  typedef logic [P+1:0][W-1:0] win_t;
  typedef enum logic [1:0] {RUN, BUBBLE, FLUSH, FBUB} state_t;
  state_t state, state_nx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [1:0] mode_q;
  logic border_q;
  logic [DATA_WIDTH-1:0] line1 [COLS];
  logic [DATA_WIDTH-1:0] line2 [COLS];
  logic [DATA_WIDTH-1:0] cur_t, cur_m, cur_b, nt, nm, nb, res;
  pix_t left_t, left_m, left_b;
  win_t s1_t, s1_m, s1_b;
  logic s1_valid, s1_sof, s1_eol;
  logic acc, feed, is_bub, gen_feed, trig, ledge;

  function automatic pix_t px(input logic [DATA_WIDTH-1:0] b, input int i);
    return b[DATA_WIDTH-1-i*W -: W];
  endfunction

  // window index 0 is the pixel left of the beat, P+1 the pixel right of it
  function automatic win_t mkwin(input logic [DATA_WIDTH-1:0] c, input pix_t l, input logic [DATA_WIDTH-1:0] n,
                                 input logic le, input logic re, input logic bq);
    win_t w;
    w[0] = le ? (bq ? px(c, 0) : '0) : l;
    for (int i = 0; i < P; i++) w[i+1] = px(c, i);
    w[P+1] = re ? (bq ? px(c, P-1) : '0) : px(n, 0);
    return w;
  endfunction

  function automatic acc_t hsum(input win_t w, input int i);
    return acc_t'(w[i]) + (acc_t'(w[i+1]) << 1) + acc_t'(w[i+2]);
  endfunction

  function automatic pix_t kern(input win_t t, input win_t m, input win_t b, input int i, input logic [1:0] md);
    acc_t g, h, v;
    g = hsum(t, i) + (hsum(m, i) << 1) + hsum(b, i) + acc_t'(8);
    h = hsum(m, i) + acc_t'(2);
    v = acc_t'(t[i+1]) + (acc_t'(m[i+1]) << 1) + acc_t'(b[i+1]) + acc_t'(2);
    return md == 2'b00 ? W'(g >> 4) : md == 2'b01 ? m[i+1] : md == 2'b10 ? W'(h >> 2) : W'(v >> 2);
  endfunction

  // the beat being fed is row r (or the synthetic row H during flush); line1/line2 hold rows r-1/r-2 at col
  always_comb begin
    in_ready = state == RUN & ~stall;
    acc = in_valid & in_ready;
    feed = acc | (state == FLUSH & ~stall);
    is_bub = state == BUBBLE | state == FBUB;
    nm = line1[col];
    nt = row == RW'(1) ? (border_q ? nm : '0) : line2[col];
    nb = state == FLUSH ? (border_q ? nm : '0) : in_frame;
    gen_feed = feed & col != '0 & (state == FLUSH | row != '0);
    trig = gen_feed | (~stall & ((state == BUBBLE & row != RW'(1)) | state == FBUB));
    ledge = ~is_bub & col == CW'(1);
    state_nx = state == RUN ? (acc & col == LAST_COL ? BUBBLE : RUN)
             : state == BUBBLE ? (row == '0 ? FLUSH : RUN)
             : state == FLUSH ? (col == LAST_COL ? FBUB : FLUSH) : RUN;
    res = '0;
    for (int i = 0; i < P; i++) res[DATA_WIDTH-1-i*W -: W] = kern(s1_t, s1_m, s1_b, i, mode_q);
  end

  always_ff @(posedge clk)
    if (!aresetn) begin
      state <= RUN;
      col <= '0;
      row <= '0;
      mode_q <= '0;
      border_q <= 1'b0;
      s1_valid <= 1'b0;
      s1_sof <= 1'b0;
      s1_eol <= 1'b0;
      out_valid <= 1'b0;
      out_sof <= 1'b0;
      out_eol <= 1'b0;
      out_frame <= '0;
    end else if (!stall) begin
      state <= state_nx;
      if (feed) col <= col == LAST_COL ? '0 : col + CW'(1);
      if (acc & col == LAST_COL) row <= row == LAST_ROW ? '0 : row + RW'(1);
      if (acc & col == '0 & row == '0) begin
        mode_q <= mode;
        border_q <= border;
      end
      s1_valid <= trig;
      s1_sof <= gen_feed & state == RUN & row == RW'(1) & col == CW'(1);
      s1_eol <= trig & is_bub;
      out_valid <= s1_valid;
      out_sof <= s1_valid & s1_sof;
      out_eol <= s1_valid & s1_eol;
      if (s1_valid) out_frame <= res;
    end

  // data path needs no reset: row 0 and the flush row never use stale buffer contents
  always_ff @(posedge clk)
    if (!stall) begin
      if (acc) begin
        line2[col] <= nm;
        line1[col] <= in_frame;
      end
      if (feed) begin
        cur_t <= nt;
        cur_m <= nm;
        cur_b <= nb;
        left_t <= px(cur_t, P-1);
        left_m <= px(cur_m, P-1);
        left_b <= px(cur_b, P-1);
      end
      if (trig) begin
        s1_t <= mkwin(cur_t, left_t, nt, ledge, is_bub, border_q);
        s1_m <= mkwin(cur_m, left_m, nm, ledge, is_bub, border_q);
        s1_b <= mkwin(cur_b, left_b, nb, ledge, is_bub, border_q);
      end
    end
endmodule
